// File: rtl/taillight_monitor.sv
// Passive checker beside the turn-signal controller: decodes the six lamps into per-side phases,
// counts completed left/right/hazard sequences and raises sticky faults on illegal codes or transitions.
module taillight_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             la,
  input  logic             lb,
  input  logic             lc,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  input  logic             clear_fault,
  output logic [1:0]       mode,
  output logic             left_done,
  output logic             right_done,
  output logic             hazard_done,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [2:0]       fault
);

  typedef enum logic [1:0] {PH_OFF, PH_P1, PH_P2, PH_P3} phase_t;

  phase_t           l_q, r_q, l_d, r_d;
  logic             l_ill, r_ill;
  logic             l_evt, r_evt, desync;
  logic             l_end, r_end, hz_end;
  logic [1:0]       mode_q, mode_d;
  logic             left_done_q, right_done_q, hazard_done_q;
  logic             left_done_d, right_done_d, hazard_done_d;
  logic [CNT_W-1:0] left_cnt_q, right_cnt_q, hazard_cnt_q;
  logic [CNT_W-1:0] left_cnt_d, right_cnt_d, hazard_cnt_d;
  logic [2:0]       fault_q, fault_d;

  function automatic logic legal_step(input phase_t p, input phase_t n);
    logic ok;
    ok = 1'b0;
    unique case (p)
      PH_OFF: ok = (n == PH_OFF) || (n == PH_P1);
      PH_P1:  ok = (n == PH_P2);
      PH_P2:  ok = (n == PH_P3);
      PH_P3:  ok = (n == PH_OFF);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] res;
    res = v;
    if (en && (v != '1)) res = v + CNT_W'(1);
    return res;
  endfunction

  // Illegal codes decode to OFF so the checker resynchronises on the next real OFF.
  always_comb begin
    l_d   = PH_OFF;
    l_ill = 1'b0;
    unique case ({la, lb, lc})
      3'b000:  l_d = PH_OFF;
      3'b100:  l_d = PH_P1;
      3'b110:  l_d = PH_P2;
      3'b111:  l_d = PH_P3;
      default: l_ill = 1'b1;
    endcase
    r_d   = PH_OFF;
    r_ill = 1'b0;
    unique case ({ra, rb, rc})
      3'b000:  r_d = PH_OFF;
      3'b100:  r_d = PH_P1;
      3'b110:  r_d = PH_P2;
      3'b111:  r_d = PH_P3;
      default: r_ill = 1'b1;
    endcase
  end

  always_comb begin
    l_evt  = l_ill || !legal_step(l_q, l_d);
    r_evt  = r_ill || !legal_step(r_q, r_d);
    desync = (l_d != PH_OFF) && (r_d != PH_OFF) && (l_d != r_d);
    l_end  = (l_q == PH_P3) && (l_d == PH_OFF) && !l_ill;
    r_end  = (r_q == PH_P3) && (r_d == PH_OFF) && !r_ill;
    hz_end = l_end && r_end;

    mode_d        = {r_d != PH_OFF, l_d != PH_OFF};
    left_done_d   = l_end && !hz_end;
    right_done_d  = r_end && !hz_end;
    hazard_done_d = hz_end;
    left_cnt_d    = sat_inc(left_cnt_q, left_done_d);
    right_cnt_d   = sat_inc(right_cnt_q, right_done_d);
    hazard_cnt_d  = sat_inc(hazard_cnt_q, hazard_done_d);
    // New events are OR-ed after the clear so a same-cycle event survives clear_fault.
    fault_d       = (clear_fault ? 3'b000 : fault_q) | {desync, r_evt, l_evt};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      l_q           <= PH_OFF;
      r_q           <= PH_OFF;
      mode_q        <= '0;
      left_done_q   <= 1'b0;
      right_done_q  <= 1'b0;
      hazard_done_q <= 1'b0;
      left_cnt_q    <= '0;
      right_cnt_q   <= '0;
      hazard_cnt_q  <= '0;
      fault_q       <= '0;
    end else begin
      l_q           <= l_d;
      r_q           <= r_d;
      mode_q        <= mode_d;
      left_done_q   <= left_done_d;
      right_done_q  <= right_done_d;
      hazard_done_q <= hazard_done_d;
      left_cnt_q    <= left_cnt_d;
      right_cnt_q   <= right_cnt_d;
      hazard_cnt_q  <= hazard_cnt_d;
      fault_q       <= fault_d;
    end
  end

  assign mode        = mode_q;
  assign left_done   = left_done_q;
  assign right_done  = right_done_q;
  assign hazard_done = hazard_done_q;
  assign left_cnt    = left_cnt_q;
  assign right_cnt   = right_cnt_q;
  assign hazard_cnt  = hazard_cnt_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_taillight_monitor.sv
// Directed bench for taillight_monitor: one default-width instance plus a CNT_W=2 instance
// sharing the same lamp stimulus for the saturation and mid-sequence reset cases.
module tb_taillight_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_fault = 1'b0;
  logic [2:0] l = 3'b000;
  logic [2:0] r = 3'b000;

  logic [1:0] mode, s_mode;
  logic       left_done, right_done, hazard_done;
  logic       s_left_done, s_right_done, s_hazard_done;
  logic [7:0] left_cnt, right_cnt, hazard_cnt;
  logic [1:0] s_left_cnt, s_right_cnt, s_hazard_cnt;
  logic [2:0] fault, s_fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  taillight_monitor #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .la(l[2]), .lb(l[1]), .lc(l[0]),
    .ra(r[2]), .rb(r[1]), .rc(r[0]),
    .clear_fault(clear_fault), .mode(mode),
    .left_done(left_done), .right_done(right_done), .hazard_done(hazard_done),
    .left_cnt(left_cnt), .right_cnt(right_cnt), .hazard_cnt(hazard_cnt),
    .fault(fault)
  );

  taillight_monitor #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .la(l[2]), .lb(l[1]), .lc(l[0]),
    .ra(r[2]), .rb(r[1]), .rc(r[0]),
    .clear_fault(clear_fault), .mode(s_mode),
    .left_done(s_left_done), .right_done(s_right_done), .hazard_done(s_hazard_done),
    .left_cnt(s_left_cnt), .right_cnt(s_right_cnt), .hazard_cnt(s_hazard_cnt),
    .fault(s_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive lamps, let one posedge sample them, then observe 1 time unit later.
  task automatic step(input logic [2:0] lv, input logic [2:0] rv);
    l = lv;
    r = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic left_seq();
    step(3'b100, 3'b000);
    step(3'b110, 3'b000);
    step(3'b111, 3'b000);
    step(3'b000, 3'b000);
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_lcnt", 32'(left_cnt), 32'd0);
    check("rst_rcnt", 32'(right_cnt), 32'd0);
    check("rst_hcnt", 32'(hazard_cnt), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_dones", 32'({left_done, right_done, hazard_done}), 32'd0);
    reset = 1'b1;

    // Left sequence
    step(3'b000, 3'b000);
    check("l_idle_mode", 32'(mode), 32'd0);
    step(3'b100, 3'b000);
    check("l_p1_mode", 32'(mode), 32'd1);
    step(3'b110, 3'b000);
    check("l_p2_mode", 32'(mode), 32'd1);
    step(3'b111, 3'b000);
    check("l_p3_mode", 32'(mode), 32'd1);
    check("l_p3_done", 32'(left_done), 32'd0);
    step(3'b000, 3'b000);
    check("l_end_mode", 32'(mode), 32'd0);
    check("l_end_done", 32'(left_done), 32'd1);
    check("l_end_cnt", 32'(left_cnt), 32'd1);
    step(3'b000, 3'b000);
    check("l_done_1cyc", 32'(left_done), 32'd0);
    check("l_fault", 32'(fault), 32'd0);

    // Hazard lockstep
    step(3'b100, 3'b100);
    check("h_p1_mode", 32'(mode), 32'd3);
    step(3'b110, 3'b110);
    step(3'b111, 3'b111);
    check("h_p3_mode", 32'(mode), 32'd3);
    step(3'b000, 3'b000);
    check("h_end_dones", 32'({left_done, right_done, hazard_done}), 32'b001);
    check("h_cnt", 32'(hazard_cnt), 32'd1);
    check("h_lcnt", 32'(left_cnt), 32'd1);
    check("h_rcnt", 32'(right_cnt), 32'd0);
    check("h_fault", 32'(fault), 32'd0);

    // Right illegal code, stickiness, clear
    step(3'b000, 3'b010);
    check("r_ill_fault", 32'(fault), 32'b010);
    check("r_ill_mode", 32'(mode), 32'd0);
    step(3'b000, 3'b100);
    step(3'b000, 3'b110);
    step(3'b000, 3'b111);
    check("r_p3_mode", 32'(mode), 32'd2);
    step(3'b000, 3'b000);
    check("r_end_done", 32'(right_done), 32'd1);
    check("r_end_cnt", 32'(right_cnt), 32'd1);
    check("r_sticky", 32'(fault), 32'b010);
    clear_fault = 1'b1;
    step(3'b000, 3'b000);
    check("clr_fault", 32'(fault), 32'b000);

    // Same-cycle clear and new event: event wins
    step(3'b010, 3'b000);
    check("clr_vs_evt", 32'(fault), 32'b001);
    clear_fault = 1'b0;
    step(3'b000, 3'b000);
    check("l_sticky", 32'(fault), 32'b001);
    clear_fault = 1'b1;
    step(3'b000, 3'b000);
    clear_fault = 1'b0;
    check("clr_fault2", 32'(fault), 32'b000);

    // Left skip OFF->P2, then finish the sequence
    step(3'b110, 3'b000);
    check("l_skip_fault", 32'(fault), 32'b001);
    step(3'b111, 3'b000);
    step(3'b000, 3'b000);
    check("l_skip_done", 32'(left_done), 32'd1);
    check("l_skip_cnt", 32'(left_cnt), 32'd2);
    clear_fault = 1'b1;
    step(3'b000, 3'b000);
    clear_fault = 1'b0;

    // Hazard desync: left leads right by one phase
    step(3'b100, 3'b000);
    step(3'b110, 3'b100);
    check("desync_fault", 32'(fault), 32'b100);
    check("desync_mode", 32'(mode), 32'd3);
    step(3'b111, 3'b110);
    step(3'b000, 3'b111);
    check("desync_ldone", 32'({left_done, right_done, hazard_done}), 32'b100);
    check("desync_lcnt", 32'(left_cnt), 32'd3);
    step(3'b000, 3'b000);
    check("desync_rdone", 32'({left_done, right_done, hazard_done}), 32'b010);
    check("desync_rcnt", 32'(right_cnt), 32'd2);
    check("desync_sticky", 32'(fault), 32'b100);

    // Saturation on the 2-bit instance
    reset = 1'b0;
    step(3'b000, 3'b000);
    step(3'b000, 3'b000);
    check("s_rst_cnt", 32'(s_left_cnt), 32'd0);
    check("s_rst_hcnt", 32'(hazard_cnt), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      left_seq();
      check($sformatf("s_done_%0d", i), 32'(s_left_done), 32'd1);
    end
    check("s_sat_cnt", 32'(s_left_cnt), 32'd3);
    check("w_cnt_4", 32'(left_cnt), 32'd4);
    check("s_fault", 32'(s_fault), 32'd0);

    // Reset mid-sequence, released with lamps still at P2
    step(3'b100, 3'b000);
    step(3'b110, 3'b000);
    reset = 1'b0;
    step(3'b110, 3'b000);
    check("mid_rst_cnt", 32'(s_left_cnt), 32'd0);
    check("mid_rst_fault", 32'(s_fault), 32'd0);
    reset = 1'b1;
    step(3'b110, 3'b000);
    check("mid_rel_fault", 32'(s_fault), 32'b001);
    check("mid_rel_cnt", 32'(s_left_cnt), 32'd0);
    check("mid_rel_done", 32'(s_left_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
